combat_referee: RTL and testbench

Parametrised per-frame combat referee for the two-player fighting game: resolves attacks into hits or blocks, tracks health, guard, stun and round timer, and runs a best-of-N round/match state machine with guard regeneration. Sits between the character/hitbox logic, which supplies overlap and block requests, and the HUD/display logic, which consumes health, guard, timer, wins and phase.

---
 rtl/combat_pkg.sv | 38 +++
 rtl/combat_if.sv | 47 ++++
 rtl/fighter_status.sv | 120 ++++++++++++
 rtl/combat_referee.sv | 194 +++++++++++++++++++
 tb/tb_combat_referee.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/combat_pkg.sv
// Shared types for the combat referee.
// Holds the round phase and winner encodings, the HUD flag bundle and a
// counter-width helper used to size the internal counters.
package combat_pkg;

  localparam int unsigned TIMER_W = 8;
  localparam int unsigned WINS_W  = 2;

  typedef enum logic [1:0] {
    PH_IDLE       = 2'd0,
    PH_FIGHT      = 2'd1,
    PH_ROUND_END  = 2'd2,
    PH_MATCH_OVER = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2,
    WIN_DRAW = 2'd3
  } winner_e;

  // Per-frame flags consumed by the HUD
  typedef struct packed {
    logic stunned1;
    logic stunned2;
    logic hit_pulse1;
    logic hit_pulse2;
    logic block_pulse1;
    logic block_pulse2;
  } hud_flags_t;

  // Bits needed to hold values 0..max_val (at least one bit)
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : 32'($clog2(max_val + 1));
  endfunction

endpackage

// File: rtl/combat_if.sv
// Bus between the character/hitbox logic, the referee and the HUD.
// master: game logic side, drives frame_tick/start/hit_req*/block* and reads
//         the status outputs.
// slave : referee side, reads the requests and drives health, guard, stun,
//         timer, wins, phase, winner and the hit/block pulses.
interface combat_if #(
  parameter int unsigned HP_W = 4
) ();

  logic            frame_tick;
  logic            start;
  logic            hit_req1;
  logic            hit_req2;
  logic            block1;
  logic            block2;

  logic [HP_W-1:0] health1;
  logic [HP_W-1:0] health2;
  logic [HP_W-1:0] guard1;
  logic [HP_W-1:0] guard2;
  logic            stunned1;
  logic            stunned2;
  logic [7:0]      timer;
  logic [1:0]      wins1;
  logic [1:0]      wins2;
  logic [1:0]      phase;
  logic [1:0]      winner;
  logic            hit_pulse1;
  logic            hit_pulse2;
  logic            block_pulse1;
  logic            block_pulse2;

  modport master (
    output frame_tick, start, hit_req1, hit_req2, block1, block2,
    input  health1, health2, guard1, guard2, stunned1, stunned2, timer,
           wins1, wins2, phase, winner, hit_pulse1, hit_pulse2,
           block_pulse1, block_pulse2
  );

  modport slave (
    input  frame_tick, start, hit_req1, hit_req2, block1, block2,
    output health1, health2, guard1, guard2, stunned1, stunned2, timer,
           wins1, wins2, phase, winner, hit_pulse1, hit_pulse2,
           block_pulse1, block_pulse2
  );

endinterface

// File: rtl/fighter_status.sv
// Health, guard, stun and guard-regen state for one player.
// Ports: clk, rst (sync, active high); i_load reloads the round values;
// i_tick is a frame tick while fighting; i_hit is the opponent's overlap
// request; i_block is this player holding back. Outputs the registered
// health/guard/stunned/pulses plus o_health_nxt_c, the post-tick health
// used by the round-end check.
module fighter_status
  import combat_pkg::*;
#(
  parameter int unsigned HEALTH_MAX         = 3,
  parameter int unsigned GUARD_MAX          = 3,
  parameter int unsigned HP_W               = 4,
  parameter int unsigned HITSTUN_FRAMES     = 10,
  parameter int unsigned BLOCKSTUN_FRAMES   = 5,
  parameter int unsigned GUARD_REGEN_FRAMES = 90
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_tick,
  input  logic            i_hit,
  input  logic            i_block,
  output logic [HP_W-1:0] o_health,
  output logic [HP_W-1:0] o_guard,
  output logic            o_stunned,
  output logic            o_hit_pulse,
  output logic            o_block_pulse,
  output logic [HP_W-1:0] o_health_nxt_c
);

  localparam int unsigned STUN_MAX = (HITSTUN_FRAMES > BLOCKSTUN_FRAMES) ?
                                     HITSTUN_FRAMES : BLOCKSTUN_FRAMES;
  localparam int unsigned ST_W = cnt_w(STUN_MAX);
  localparam int unsigned RG_W = cnt_w(GUARD_REGEN_FRAMES - 1);

  logic [HP_W-1:0] r_health, w_health_nxt;
  logic [HP_W-1:0] r_guard,  w_guard_nxt;
  logic [ST_W-1:0] r_stun,   w_stun_nxt;
  logic [RG_W-1:0] r_regen,  w_regen_nxt;
  logic            r_stunned;
  logic            r_hit_pulse,   w_hit_pulse_nxt;
  logic            r_block_pulse, w_block_pulse_nxt;
  logic            w_block_taken;

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_health      <= HP_W'(HEALTH_MAX);
      r_guard       <= HP_W'(GUARD_MAX);
      r_stun        <= '0;
      r_regen       <= '0;
      r_stunned     <= 1'b0;
      r_hit_pulse   <= 1'b0;
      r_block_pulse <= 1'b0;
    end else begin
      r_health      <= w_health_nxt;
      r_guard       <= w_guard_nxt;
      r_stun        <= w_stun_nxt;
      r_regen       <= w_regen_nxt;
      r_stunned     <= (w_stun_nxt != '0);
      r_hit_pulse   <= w_hit_pulse_nxt;
      r_block_pulse <= w_block_pulse_nxt;
    end
  end

  // Per-tick combat resolution, all decisions on start-of-tick values
  always_comb begin
    w_health_nxt      = r_health;
    w_guard_nxt       = r_guard;
    w_stun_nxt        = r_stun;
    w_regen_nxt       = r_regen;
    w_hit_pulse_nxt   = 1'b0;
    w_block_pulse_nxt = 1'b0;
    w_block_taken     = 1'b0;
    if (i_load) begin
      w_health_nxt = HP_W'(HEALTH_MAX);
      w_guard_nxt  = HP_W'(GUARD_MAX);
      w_stun_nxt   = '0;
      w_regen_nxt  = '0;
    end else if (i_tick) begin
      if (r_stun != '0) begin
        w_stun_nxt = r_stun - ST_W'(1);
      end
      // A stunned defender is immune to new hits
      if (i_hit && (r_stun == '0)) begin
        if (i_block && (r_guard != '0)) begin
          w_guard_nxt       = r_guard - HP_W'(1);
          w_stun_nxt        = ST_W'(BLOCKSTUN_FRAMES);
          w_block_pulse_nxt = 1'b1;
          w_block_taken     = 1'b1;
        end else begin
          if (r_health != '0) begin
            w_health_nxt = r_health - HP_W'(1);
          end
          w_stun_nxt      = ST_W'(HITSTUN_FRAMES);
          w_hit_pulse_nxt = 1'b1;
        end
      end
      // Regen counts only while idle below the ceiling; spending guard restarts it
      if (w_block_taken || (r_guard == HP_W'(GUARD_MAX))) begin
        w_regen_nxt = '0;
      end else if (r_stun == '0) begin
        if (r_regen == RG_W'(GUARD_REGEN_FRAMES - 1)) begin
          w_guard_nxt = r_guard + HP_W'(1);
          w_regen_nxt = '0;
        end else begin
          w_regen_nxt = r_regen + RG_W'(1);
        end
      end
    end
  end

  assign o_health       = r_health;
  assign o_guard        = r_guard;
  assign o_stunned      = r_stunned;
  assign o_hit_pulse    = r_hit_pulse;
  assign o_block_pulse  = r_block_pulse;
  assign o_health_nxt_c = w_health_nxt;

endmodule

// File: rtl/combat_referee.sv
// Two-player combat referee: round timer, round/match FSM, win counters and
// winner logic around two fighter_status instances.
// Ports: clk, rst (sync, active high) and bus (combat_if slave) carrying the
// frame tick, start, hit/block requests and all HUD-facing status outputs.
module combat_referee
  import combat_pkg::*;
#(
  parameter int unsigned HEALTH_MAX         = 3,
  parameter int unsigned GUARD_MAX          = 3,
  parameter int unsigned HP_W               = 4,
  parameter int unsigned HITSTUN_FRAMES     = 10,
  parameter int unsigned BLOCKSTUN_FRAMES   = 5,
  parameter int unsigned GUARD_REGEN_FRAMES = 90,
  parameter int unsigned FRAMES_PER_SEC     = 60,
  parameter int unsigned ROUND_SECONDS      = 99,
  parameter int unsigned ROUNDS_TO_WIN      = 2,
  parameter int unsigned ROUND_END_FRAMES   = 120
) (
  input logic     clk,
  input logic     rst,
  combat_if.slave bus
);

  localparam int unsigned FR_W = cnt_w(FRAMES_PER_SEC - 1);
  localparam int unsigned PZ_W = cnt_w(ROUND_END_FRAMES - 1);

  phase_e             r_phase,  w_phase_nxt;
  winner_e            r_winner, w_winner_nxt, w_round_winner;
  logic [TIMER_W-1:0] r_timer,  w_timer_nxt;
  logic [FR_W-1:0]    r_frame,  w_frame_nxt;
  logic [PZ_W-1:0]    r_pause,  w_pause_nxt;
  logic [WINS_W-1:0]  r_wins1,  w_wins1_nxt;
  logic [WINS_W-1:0]  r_wins2,  w_wins2_nxt;
  logic               w_load;
  logic               w_fight_tick;
  logic               w_ko1, w_ko2, w_round_over;
  logic [HP_W-1:0]    w_health1, w_health2, w_guard1, w_guard2;
  logic [HP_W-1:0]    w_health1_nxt, w_health2_nxt;
  logic               w_stunned1, w_stunned2;
  logic               w_hit_pulse1, w_hit_pulse2, w_block_pulse1, w_block_pulse2;
  hud_flags_t         w_flags;

  assign w_fight_tick = bus.frame_tick && (r_phase == PH_FIGHT);

  // Player 1 defends against P2's requests, and vice versa
  fighter_status #(
    .HEALTH_MAX(HEALTH_MAX), .GUARD_MAX(GUARD_MAX), .HP_W(HP_W),
    .HITSTUN_FRAMES(HITSTUN_FRAMES), .BLOCKSTUN_FRAMES(BLOCKSTUN_FRAMES),
    .GUARD_REGEN_FRAMES(GUARD_REGEN_FRAMES)
  ) u_p1 (
    .clk(clk), .rst(rst), .i_load(w_load), .i_tick(w_fight_tick),
    .i_hit(bus.hit_req2), .i_block(bus.block1),
    .o_health(w_health1), .o_guard(w_guard1), .o_stunned(w_stunned1),
    .o_hit_pulse(w_hit_pulse1), .o_block_pulse(w_block_pulse1),
    .o_health_nxt_c(w_health1_nxt)
  );

  fighter_status #(
    .HEALTH_MAX(HEALTH_MAX), .GUARD_MAX(GUARD_MAX), .HP_W(HP_W),
    .HITSTUN_FRAMES(HITSTUN_FRAMES), .BLOCKSTUN_FRAMES(BLOCKSTUN_FRAMES),
    .GUARD_REGEN_FRAMES(GUARD_REGEN_FRAMES)
  ) u_p2 (
    .clk(clk), .rst(rst), .i_load(w_load), .i_tick(w_fight_tick),
    .i_hit(bus.hit_req1), .i_block(bus.block2),
    .o_health(w_health2), .o_guard(w_guard2), .o_stunned(w_stunned2),
    .o_hit_pulse(w_hit_pulse2), .o_block_pulse(w_block_pulse2),
    .o_health_nxt_c(w_health2_nxt)
  );

  // Round/match state and timer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase  <= PH_IDLE;
      r_winner <= WIN_NONE;
      r_timer  <= TIMER_W'(ROUND_SECONDS);
      r_frame  <= '0;
      r_pause  <= '0;
      r_wins1  <= '0;
      r_wins2  <= '0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_winner <= w_winner_nxt;
      r_timer  <= w_timer_nxt;
      r_frame  <= w_frame_nxt;
      r_pause  <= w_pause_nxt;
      r_wins1  <= w_wins1_nxt;
      r_wins2  <= w_wins2_nxt;
    end
  end

  // Next-state: timer, round-end judgement and match progression
  always_comb begin
    w_phase_nxt    = r_phase;
    w_winner_nxt   = r_winner;
    w_timer_nxt    = r_timer;
    w_frame_nxt    = r_frame;
    w_pause_nxt    = r_pause;
    w_wins1_nxt    = r_wins1;
    w_wins2_nxt    = r_wins2;
    w_load         = 1'b0;
    w_ko1          = 1'b0;
    w_ko2          = 1'b0;
    w_round_over   = 1'b0;
    w_round_winner = WIN_NONE;
    case (r_phase)
      PH_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_phase_nxt = PH_FIGHT;
        end
      end
      PH_FIGHT: begin
        if (bus.frame_tick) begin
          if (r_frame == FR_W'(FRAMES_PER_SEC - 1)) begin
            w_frame_nxt = '0;
            if (r_timer != '0) begin
              w_timer_nxt = r_timer - TIMER_W'(1);
            end
          end else begin
            w_frame_nxt = r_frame + FR_W'(1);
          end
          // Judged on the values this tick produces
          w_ko1        = (w_health1_nxt == '0);
          w_ko2        = (w_health2_nxt == '0);
          w_round_over = w_ko1 || w_ko2 || (w_timer_nxt == '0);
          if (w_round_over) begin
            if (w_ko1 && w_ko2)                    w_round_winner = WIN_DRAW;
            else if (w_ko1)                        w_round_winner = WIN_P2;
            else if (w_ko2)                        w_round_winner = WIN_P1;
            else if (w_health1_nxt > w_health2_nxt) w_round_winner = WIN_P1;
            else if (w_health2_nxt > w_health1_nxt) w_round_winner = WIN_P2;
            else                                   w_round_winner = WIN_DRAW;
            if (w_round_winner == WIN_P1) w_wins1_nxt = r_wins1 + WINS_W'(1);
            if (w_round_winner == WIN_P2) w_wins2_nxt = r_wins2 + WINS_W'(1);
            w_winner_nxt = w_round_winner;
            w_phase_nxt  = PH_ROUND_END;
          end
        end
      end
      PH_ROUND_END: begin
        if (bus.frame_tick) begin
          if (r_pause == PZ_W'(ROUND_END_FRAMES - 1)) begin
            w_pause_nxt = '0;
            if ((r_wins1 == WINS_W'(ROUNDS_TO_WIN)) ||
                (r_wins2 == WINS_W'(ROUNDS_TO_WIN))) begin
              w_phase_nxt  = PH_MATCH_OVER;
              w_winner_nxt = (r_wins1 == WINS_W'(ROUNDS_TO_WIN)) ? WIN_P1 : WIN_P2;
            end else begin
              w_load      = 1'b1;
              w_phase_nxt = PH_FIGHT;
            end
          end else begin
            w_pause_nxt = r_pause + PZ_W'(1);
          end
        end
      end
      PH_MATCH_OVER: begin
        if (bus.start) begin
          w_wins1_nxt  = '0;
          w_wins2_nxt  = '0;
          w_winner_nxt = WIN_NONE;
          w_load       = 1'b1;
          w_phase_nxt  = PH_FIGHT;
        end
      end
    endcase
    // Round load restarts the clock alongside the fighters
    if (w_load) begin
      w_timer_nxt = TIMER_W'(ROUND_SECONDS);
      w_frame_nxt = '0;
    end
  end

  assign w_flags = '{stunned1: w_stunned1, stunned2: w_stunned2,
                     hit_pulse1: w_hit_pulse1, hit_pulse2: w_hit_pulse2,
                     block_pulse1: w_block_pulse1, block_pulse2: w_block_pulse2};

  assign bus.health1      = w_health1;
  assign bus.health2      = w_health2;
  assign bus.guard1       = w_guard1;
  assign bus.guard2       = w_guard2;
  assign bus.stunned1     = w_flags.stunned1;
  assign bus.stunned2     = w_flags.stunned2;
  assign bus.hit_pulse1   = w_flags.hit_pulse1;
  assign bus.hit_pulse2   = w_flags.hit_pulse2;
  assign bus.block_pulse1 = w_flags.block_pulse1;
  assign bus.block_pulse2 = w_flags.block_pulse2;
  assign bus.timer        = r_timer;
  assign bus.wins1        = r_wins1;
  assign bus.wins2        = r_wins2;
  assign bus.phase        = r_phase;
  assign bus.winner       = r_winner;

endmodule

// File: tb/tb_combat_referee.sv
// Scoreboard bench for combat_referee: the driver applies one input vector
// per cycle, advances a behavioural game model and queues the expected HUD
// snapshot; the monitor pops and compares one snapshot per cycle.
module tb_combat_referee;

  localparam int HMAX = 3, GMAX = 3, HITS = 10, BLKS = 5, REGEN = 90;
  localparam int FPS = 2, RSEC = 100, RTW = 2, REF = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  combat_if #(.HP_W(4)) bus ();

  combat_referee #(
    .HEALTH_MAX(HMAX), .GUARD_MAX(GMAX), .HP_W(4),
    .HITSTUN_FRAMES(HITS), .BLOCKSTUN_FRAMES(BLKS),
    .GUARD_REGEN_FRAMES(REGEN), .FRAMES_PER_SEC(FPS),
    .ROUND_SECONDS(RSEC), .ROUNDS_TO_WIN(RTW), .ROUND_END_FRAMES(REF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [3:0] health1, health2, guard1, guard2;
    logic       stunned1, stunned2;
    logic [7:0] timer;
    logic [1:0] wins1, wins2, phase, winner;
    logic       hit_pulse1, hit_pulse2, block_pulse1, block_pulse2;
  } snap_t;

  snap_t exp_q[$];
  string tag_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  // Game model: index 0 is player 1, index 1 is player 2
  int m_hp[2], m_gd[2], m_st[2], m_rg[2], m_wins[2];
  bit m_hpul[2], m_bpul[2];
  int m_timer, m_frames, m_phase, m_winner, m_pause;

  function automatic void model_load();
    for (int p = 0; p < 2; p++) begin
      m_hp[p] = HMAX; m_gd[p] = GMAX; m_st[p] = 0; m_rg[p] = 0;
    end
    m_timer  = RSEC;
    m_frames = 0;
  endfunction

  function automatic void model_reset();
    model_load();
    for (int p = 0; p < 2; p++) begin
      m_wins[p] = 0; m_hpul[p] = 1'b0; m_bpul[p] = 1'b0;
    end
    m_phase = 0; m_winner = 0; m_pause = 0;
  endfunction

  function automatic void model_step(bit tk, bit st, bit h1, bit h2, bit b1, bit b2);
    bit incoming[2];
    bit holding[2];
    incoming[0] = h2; incoming[1] = h1;
    holding[0]  = b1; holding[1]  = b2;
    for (int p = 0; p < 2; p++) begin
      m_hpul[p] = 1'b0; m_bpul[p] = 1'b0;
    end
    case (m_phase)
      0: if (st) begin model_load(); m_phase = 1; end
      1: if (tk) begin
        for (int p = 0; p < 2; p++) begin
          int  stun0, guard0;
          bit  blocked;
          stun0   = m_st[p];
          guard0  = m_gd[p];
          blocked = 1'b0;
          m_st[p] = (stun0 > 0) ? stun0 - 1 : 0;
          if (incoming[p] && stun0 == 0) begin
            if (holding[p] && guard0 > 0) begin
              m_gd[p] = guard0 - 1; m_st[p] = BLKS; m_bpul[p] = 1'b1; blocked = 1'b1;
            end else begin
              m_hp[p] = (m_hp[p] > 0) ? m_hp[p] - 1 : 0;
              m_st[p] = HITS; m_hpul[p] = 1'b1;
            end
          end
          if (blocked || guard0 == GMAX) m_rg[p] = 0;
          else if (stun0 == 0) begin
            m_rg[p]++;
            if (m_rg[p] == REGEN) begin m_gd[p]++; m_rg[p] = 0; end
          end
        end
        m_frames++;
        if (m_frames == FPS) begin
          m_frames = 0;
          if (m_timer > 0) m_timer--;
        end
        // Whoever has more health takes the round; equal health is a draw
        if (m_hp[0] == 0 || m_hp[1] == 0 || m_timer == 0) begin
          if (m_hp[0] == m_hp[1]) m_winner = 3;
          else m_winner = (m_hp[0] > m_hp[1]) ? 1 : 2;
          if (m_winner != 3) m_wins[m_winner-1]++;
          m_phase = 2;
        end
      end
      2: if (tk) begin
        m_pause++;
        if (m_pause == REF) begin
          m_pause = 0;
          if (m_wins[0] == RTW || m_wins[1] == RTW) begin
            m_phase = 3; m_winner = (m_wins[0] == RTW) ? 1 : 2;
          end else begin
            model_load(); m_phase = 1;
          end
        end
      end
      default: if (st) begin
        m_wins[0] = 0; m_wins[1] = 0; m_winner = 0; model_load(); m_phase = 1;
      end
    endcase
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.health1 = 4'(m_hp[0]);  s.health2 = 4'(m_hp[1]);
    s.guard1  = 4'(m_gd[0]);  s.guard2  = 4'(m_gd[1]);
    s.stunned1 = (m_st[0] != 0); s.stunned2 = (m_st[1] != 0);
    s.timer   = 8'(m_timer);
    s.wins1   = 2'(m_wins[0]); s.wins2 = 2'(m_wins[1]);
    s.phase   = 2'(m_phase);   s.winner = 2'(m_winner);
    s.hit_pulse1 = m_hpul[0];  s.hit_pulse2 = m_hpul[1];
    s.block_pulse1 = m_bpul[0]; s.block_pulse2 = m_bpul[1];
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.health1 = bus.health1;   s.health2 = bus.health2;
    s.guard1  = bus.guard1;    s.guard2  = bus.guard2;
    s.stunned1 = bus.stunned1; s.stunned2 = bus.stunned2;
    s.timer   = bus.timer;
    s.wins1   = bus.wins1;     s.wins2  = bus.wins2;
    s.phase   = bus.phase;     s.winner = bus.winner;
    s.hit_pulse1 = bus.hit_pulse1;     s.hit_pulse2 = bus.hit_pulse2;
    s.block_pulse1 = bus.block_pulse1; s.block_pulse2 = bus.block_pulse2;
    return s;
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("ph=%0d win=%0d wins=%0d/%0d tm=%0d hp=%0d/%0d gd=%0d/%0d stn=%0d%0d hitp=%0d%0d blkp=%0d%0d",
                     s.phase, s.winner, s.wins1, s.wins2, s.timer, s.health1, s.health2,
                     s.guard1, s.guard2, s.stunned1, s.stunned2, s.hit_pulse1, s.hit_pulse2,
                     s.block_pulse1, s.block_pulse2);
  endfunction

  function automatic bit rb(int unsigned pct);
    return ($urandom_range(99, 0) < pct);
  endfunction

  task automatic step(input string tag, input bit tk, input bit st,
                      input bit h1, input bit h2, input bit b1, input bit b2);
    @(negedge clk);
    rst = 1'b0;
    bus.frame_tick = tk; bus.start = st;
    bus.hit_req1 = h1; bus.hit_req2 = h2; bus.block1 = b1; bus.block2 = b2;
    model_step(tk, st, h1, h2, b1, b2);
    exp_q.push_back(model_snap());
    tag_q.push_back(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    bus.frame_tick = rb(50); bus.start = rb(50);
    bus.hit_req1 = rb(50); bus.hit_req2 = rb(50); bus.block1 = rb(50); bus.block2 = rb(50);
    model_reset();
    exp_q.push_back(model_snap());
    tag_q.push_back(tag);
  endtask

  // n frame ticks, each followed by a non-tick cycle with noise on the requests
  task automatic ticks(input string tag, input int n,
                       input bit h1, input bit h2, input bit b1, input bit b2);
    for (int i = 0; i < n; i++) begin
      step(tag, 1'b1, 1'b0, h1, h2, b1, b2);
      step({tag, "_gap"}, 1'b0, 1'b0, rb(50), rb(50), rb(50), rb(50));
    end
  endtask

  // Monitor: one expected snapshot per cycle, sampled after the edge
  initial begin
    snap_t a, e;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = dut_snap();
        n_cmp++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s t=%0t actual[%s] required[%s]", t, $time, fmt(a), fmt(e));
        end
      end
    end
  end

  initial begin
    bus.frame_tick = 1'b0; bus.start = 1'b0;
    bus.hit_req1 = 1'b0; bus.hit_req2 = 1'b0; bus.block1 = 1'b0; bus.block2 = 1'b0;

    // Reset state, idle ticks, first unblocked hit
    do_reset("reset_state");
    ticks("idle_tick", 3, 1'b1, 1'b1, 1'b1, 1'b0);
    step("start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks("hit_p2", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks("after_hit", 3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Block, blockstun immunity for 5 ticks, accepted on the 6th
    do_reset("reset2");
    step("start2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks("block_p2", 1, 1'b1, 1'b0, 1'b0, 1'b1);
    ticks("blockstun", 5, 1'b1, 1'b0, 1'b0, 1'b1);
    ticks("after_blockstun", 1, 1'b1, 1'b0, 1'b0, 1'b1);

    // Guard regen with a restart one tick short of completion
    do_reset("reset3");
    step("start3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks("regen_block", 1, 1'b1, 1'b0, 1'b0, 1'b1);
    ticks("regen_wait", 94, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks("regen_restart", 1, 1'b1, 1'b0, 1'b0, 1'b1);
    ticks("regen_full", 95, 1'b0, 1'b0, 1'b0, 1'b0);

    // Trades down to a double KO draw, then the pause
    do_reset("reset4");
    step("start4", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      ticks("trade", 1, 1'b1, 1'b1, 1'b0, 1'b0);
      if (k < 2) ticks("trade_stun", 10, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    ticks("draw_pause", REF, 1'b0, 1'b0, 1'b0, 1'b0);

    // Time-out round decided on health, then reload
    do_reset("reset5");
    step("start5", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks("chip_p2", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks("timeout", 199, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks("timeout_pause", REF, 1'b0, 1'b0, 1'b0, 1'b0);

    // Second round by KO ends the match; restart; reset during the pause
    for (int k = 0; k < 3; k++) begin
      ticks("ko_hit", 1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (k < 2) ticks("ko_stun", 10, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    ticks("match_pause", REF, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks("match_hold", 3, 1'b1, 1'b1, 1'b0, 1'b0);
    step("match_restart", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      ticks("ko2_hit", 1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (k < 2) ticks("ko2_stun", 10, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    ticks("mid_pause", 3, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset("reset_mid_pause");
    step("post_reset_idle", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Random play
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(999, 0) == 0) do_reset("rand_reset");
      else step("random", rb(70), rb(3), rb(35), rb(35), rb(50), rb(50));
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
